// File: rtl/sample_timer_pkg.sv
// sample_timer_pkg -- shared definitions for the sample_timer block.
//   state_e          : frame FSM encoding (IDLE, RUN, DONE)
//   DEF_PERIOD_BITS  : default width of the clocks-per-bit count
//   DEF_BIT_BITS     : default width of the bits-per-frame count
package sample_timer_pkg;

  localparam int DEF_PERIOD_BITS = 4;
  localparam int DEF_BIT_BITS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sample_timer_rate_counter.sv
// rate_counter -- loadable up-counter with a programmable wrap point.
//   clk, n_rst : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val this edge (takes priority over enable)
//   load_val   : value loaded on load
//   enable     : advance this edge
//   wrap_val   : when count equals this, the next advance goes to wrap_to
//   wrap_to    : value taken after an advance from wrap_val
//   count      : current registered count
//   terminal   : count == wrap_val
module rate_counter
  import sample_timer_pkg::*;
#(
  parameter int W = DEF_PERIOD_BITS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  input  logic [W-1:0] wrap_val,
  input  logic [W-1:0] wrap_to,
  output logic [W-1:0] count,
  output logic         terminal
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      if (count_q == wrap_val) begin
        count_d = wrap_to;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == wrap_val);

endmodule

// File: rtl/sample_timer.sv
// sample_timer -- frame timer producing one sample strobe per bit period.
//   clk, n_rst     : clock, asynchronous active-low reset
//   start          : begins a frame when idle (level, sampled every edge)
//   stop           : aborts a running frame (no frame_done)
//   bit_period     : clocks per bit P (latched at start, 0 treated as 1)
//   bits_per_frame : bits per frame N (latched at start, 0 treated as 1)
//   sample_strobe  : one-cycle pulse per bit
//   frame_done     : one-cycle pulse in the DONE state
//   busy           : high in RUN and DONE
//   bit_count      : bits completed in the current/last frame
// Optional build macro SAMPLE_TIMER_MIDBIT_EN moves the strobe to the middle
// of each bit period, at period count (P+1)>>1; bit and frame timing unchanged.
// All outputs are decoded from registered state and counters only.
module sample_timer
  import sample_timer_pkg::*;
#(
  parameter int PERIOD_BITS = DEF_PERIOD_BITS,
  parameter int BIT_BITS    = DEF_BIT_BITS
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PERIOD_BITS-1:0] bit_period,
  input  logic [BIT_BITS-1:0]    bits_per_frame,
  output logic                   sample_strobe,
  output logic                   frame_done,
  output logic                   busy,
  output logic [BIT_BITS-1:0]    bit_count
);

  state_e                 state_q, state_d;
  logic [PERIOD_BITS-1:0] per_lat_q, per_lat_d;
  logic [BIT_BITS-1:0]    bits_lat_q, bits_lat_d;

  logic                   per_load, per_en, per_term;
  logic                   bit_load, bit_en, bit_last;
  logic [PERIOD_BITS-1:0] period_cnt;
  logic [BIT_BITS-1:0]    bit_cnt;
  logic [BIT_BITS-1:0]    bits_last_val;
  logic                   strobe_hit;

  // The bit counter's wrap point is N-1 and it "wraps" to N, so its
  // terminal flag marks the last bit and the final advance parks it at N.
  assign bits_last_val = bits_lat_q - BIT_BITS'(1);

  rate_counter #(.W(PERIOD_BITS)) u_period_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (per_load),
    .load_val (PERIOD_BITS'(1)),
    .enable   (per_en),
    .wrap_val (per_lat_q),
    .wrap_to  (PERIOD_BITS'(1)),
    .count    (period_cnt),
    .terminal (per_term)
  );

  rate_counter #(.W(BIT_BITS)) u_bit_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (bit_load),
    .load_val ('0),
    .enable   (bit_en),
    .wrap_val (bits_last_val),
    .wrap_to  (bits_lat_q),
    .count    (bit_cnt),
    .terminal (bit_last)
  );

`ifdef SAMPLE_TIMER_MIDBIT_EN
  // One extra bit so P = all-ones does not overflow before the halving.
  logic [PERIOD_BITS:0] mid_sum;
  assign mid_sum    = {1'b0, per_lat_q} + {{PERIOD_BITS{1'b0}}, 1'b1};
  assign strobe_hit = (period_cnt == mid_sum[PERIOD_BITS:1]);
`else
  assign strobe_hit = per_term;
`endif

  always_comb begin
    state_d    = state_q;
    per_lat_d  = per_lat_q;
    bits_lat_d = bits_lat_q;
    per_load   = 1'b0;
    per_en     = 1'b0;
    bit_load   = 1'b0;
    bit_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          per_lat_d  = (bit_period == '0) ? PERIOD_BITS'(1) : bit_period;
          bits_lat_d = (bits_per_frame == '0) ? BIT_BITS'(1) : bits_per_frame;
          per_load   = 1'b1;
          bit_load   = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop wins over the end-of-bit advance and the DONE transition.
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          per_en = 1'b1;
          if (per_term) begin
            bit_en = 1'b1;
            if (bit_last) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      per_lat_q  <= '0;
      bits_lat_q <= '0;
    end else begin
      state_q    <= state_d;
      per_lat_q  <= per_lat_d;
      bits_lat_q <= bits_lat_d;
    end
  end

  assign sample_strobe = (state_q == ST_RUN) && strobe_hit;
  assign frame_done    = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign bit_count     = bit_cnt;

endmodule

// File: tb/tb_sample_timer.sv
// tb_sample_timer -- scoreboard bench for sample_timer.
// Stimulus pushes the hand-computed strobe / frame_done events of each frame
// into a queue; a monitor pops one entry for every output event and compares
// kind, cycle and bit_count. Build with SAMPLE_TIMER_MIDBIT_EN defined to
// check the mid-bit strobe variant.
module tb_sample_timer;

  localparam int PB = 4;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PB-1:0] bit_period = '0;
  logic [BB-1:0] bits_per_frame = '0;
  logic          sample_strobe;
  logic          frame_done;
  logic          busy;
  logic [BB-1:0] bit_count;

  sample_timer #(.PERIOD_BITS(PB), .BIT_BITS(BB)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .stop           (stop),
    .bit_period     (bit_period),
    .bits_per_frame (bits_per_frame),
    .sample_strobe  (sample_strobe),
    .frame_done     (frame_done),
    .busy           (busy),
    .bit_count      (bit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int bc;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   base     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected events, k = RUN-relative cycle (RUN cycle 1 is the first after start).
  task automatic exp_s(input int k, input int bc);
    exp_q.push_back('{is_done: 1'b0, cyc: base + k - 1, bc: bc});
  endtask

  task automatic exp_d(input int k, input int bc);
    exp_q.push_back('{is_done: 1'b1, cyc: base + k - 1, bc: bc});
  endtask

  // Called at a negedge: start is sampled at the next posedge.
  task automatic arm(input int p, input int n);
    bit_period     = PB'(p);
    bits_per_frame = BB'(n);
    start          = 1'b1;
    base           = cyc + 1;
  endtask

  // Drop start; returns at the negedge of RUN cycle 1.
  task automatic go();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_k(input int k);
    int guard = 0;
    while (cyc != base + k - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("wait_timeout", 1, 0);
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // P=4, N=3 single-cycle start.
  task automatic normal_frame(input string tag);
    int busy_cnt = 0;
    arm(4, 3);
`ifdef SAMPLE_TIMER_MIDBIT_EN
    exp_s(2, 0); exp_s(6, 1); exp_s(10, 2);
`else
    exp_s(4, 0); exp_s(8, 1); exp_s(12, 2);
`endif
    exp_d(13, 3);
    go();
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(busy);
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, busy_cnt, 13);
    chk({tag, "_bit_count_after"}, bit_count, 3);
    drain({tag, "_missing_events"});
  endtask

  // Monitor: one scoreboard pop per output event.
  always @(negedge clk) begin
    if (n_rst && (sample_strobe || frame_done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: strobe=%0b done=%0b at cycle %0d, required none",
                 sample_strobe, frame_done, cyc);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("event_kind_done", frame_done, e.is_done);
        chk("event_cycle", cyc, e.cyc);
        chk("event_bit_count", bit_count, e.bc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1 n_rst = 1'b0;
    idle(2);
    chk("rst_sample_strobe", sample_strobe, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_count", bit_count, 0);
    n_rst = 1'b1;
    idle(2);

    // Basic frame P=4, N=3.
    normal_frame("basic");

    // P=5, N=2.
    arm(5, 2);
`ifdef SAMPLE_TIMER_MIDBIT_EN
    exp_s(3, 0); exp_s(8, 1);
`else
    exp_s(5, 0); exp_s(10, 1);
`endif
    exp_d(11, 2);
    go();
    idle(14);
    chk("p5n2_bit_count", bit_count, 2);
    drain("p5n2_missing_events");

    // Stop in RUN cycle 8 (P=4, N=3): strobe visible, no frame_done, bit_count=1.
    arm(4, 3);
`ifdef SAMPLE_TIMER_MIDBIT_EN
    exp_s(2, 0); exp_s(6, 1);
`else
    exp_s(4, 0); exp_s(8, 1);
`endif
    go();
    wait_k(8);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy_next", busy, 0);
    chk("stop_bit_count", bit_count, 1);
    idle(8);
    drain("stop_missing_events");

    // Stop while idle has no effect.
    stop = 1'b1;
    idle(2);
    stop = 1'b0;
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_bit_count", bit_count, 1);

    // P=0, N=0 clamp to 1.
    arm(0, 0);
    exp_s(1, 0);
    exp_d(2, 1);
    go();
    idle(4);
    chk("clamp_bit_count", bit_count, 1);
    chk("clamp_busy", busy, 0);
    drain("clamp_missing_events");

    // Reset asserted in RUN cycle 6: outputs clear at once, then a normal frame.
    arm(4, 3);
`ifdef SAMPLE_TIMER_MIDBIT_EN
    exp_s(2, 0); exp_s(6, 1);
`else
    exp_s(4, 0);
`endif
    go();
    wait_k(6);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_sample_strobe", sample_strobe, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_count", bit_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    drain("midrst_missing_events");
    idle(1);
    normal_frame("after_rst");

    // start held high, P=2, N=1: frame every 4 cycles, mid-frame P change ignored.
    arm(2, 1);
    for (int f = 0; f < 3; f++) begin
`ifdef SAMPLE_TIMER_MIDBIT_EN
      exp_s(1 + 4 * f, 0);
`else
      exp_s(2 + 4 * f, 0);
`endif
      exp_d(3 + 4 * f, 1);
    end
    @(negedge clk);
    bit_period = PB'(7);
    wait_k(3);
    bit_period = PB'(2);
    wait_k(12);
    start = 1'b0;
    idle(4);
    chk("held_busy_end", busy, 0);
    chk("held_bit_count", bit_count, 1);
    drain("held_missing_events");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_timer.md
SAMPLE_TIMER -- requirements
Module: sample_timer

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 4, width of the clocks-per-bit period count.
REQ-002 SHALL have parameter BIT_BITS, default 4, width of the bits-per-frame count.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  level, sampled each clk; begins a frame when idle.
REQ-006 SHALL have port stop  input  1  level; aborts a running frame.
REQ-007 SHALL have port bit_period  input  PERIOD_BITS  clocks per bit (P).
REQ-008 SHALL have port bits_per_frame  input  BIT_BITS  bits per frame (N).
REQ-009 SHALL have port sample_strobe  output  1  one-cycle sample pulse per bit.
REQ-010 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-011 SHALL have port busy  output  1  high while a frame runs.
REQ-012 SHALL have port bit_count  output  BIT_BITS  bits completed in current frame.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs decoded from registered state and counters only, with no combinational input-to-output path.
REQ-014 In IDLE, start=1 at an edge SHALL latch P and N, load period_cnt=1 and bit_cnt=0, and enter RUN.
REQ-015 Latched P=0 or N=0 SHALL be clamped to 1.
REQ-016 bit_period and bits_per_frame changes during RUN SHALL be ignored until the next start.
REQ-017 In RUN, period_cnt SHALL increment each cycle and wrap from P to 1.
REQ-018 At period_cnt==P, bit_cnt SHALL increment at the following edge.
REQ-019 sample_strobe SHALL be high in RUN during cycles with period_cnt==P; first strobe is in the Pth RUN cycle.
REQ-020 At period_cnt==P with bit_cnt==N-1, next state SHALL be DONE, with bit_cnt==N in DONE.
REQ-021 DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE; bit_count holds N until the next start.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 stop=1 in RUN SHALL force IDLE at the next edge with no frame_done; stop overrides a coincident strobe/DONE transition, though sample_strobe stays visible that cycle.
REQ-024 start in RUN or DONE SHALL be ignored; start held high through DONE SHALL begin a new frame from IDLE one cycle later.
REQ-025 stop in IDLE or DONE SHALL have no effect.
REQ-026 Counters SHALL never exceed latched P or N and SHALL NOT wrap through zero.

Reset
REQ-027 n_rst=0 SHALL asynchronously force IDLE, period_cnt=0, bit_cnt=0, latched P/N=0.
REQ-028 n_rst=0 SHALL asynchronously force sample_strobe=0, frame_done=0, busy=0, bit_count=0.
REQ-029 Reset asserted mid-frame SHALL abort without frame_done; first start after release SHALL behave as from power-up.

Configuration
REQ-030 With SAMPLE_TIMER_MIDBIT_EN defined, sample_strobe SHALL fire at period_cnt==(P+1)>>1 instead of P; bit_cnt advance and DONE timing are unchanged.
REQ-031 Without SAMPLE_TIMER_MIDBIT_EN, sample_strobe SHALL fire at period_cnt==P, per REQ-019.

Structure
REQ-032 The state enum (IDLE, RUN, DONE) SHALL live in shared package sample_timer_pkg.
REQ-033 Default width constants SHALL live in shared package sample_timer_pkg.
REQ-034 period_cnt and bit_cnt SHALL each be an instance of one sub-module, rate_counter, with load, enable, wrap value, and terminal flag; FSM in sample_timer.

Verification
REQ-035 SHALL cover: P=4, N=3, start 1 cycle -> strobes in RUN cycles 4,8,12; frame_done in cycle 13; busy for 13 cycles; bit_count=3 after.
REQ-036 SHALL cover: P=5, N=2, SAMPLE_TIMER_MIDBIT_EN -> strobes in RUN cycles 3,8; frame_done in cycle 11.
REQ-037 SHALL cover: P=4, N=3, stop in RUN cycle 8 -> strobe seen cycle 8; IDLE next; no frame_done; bit_count=1.
REQ-038 SHALL cover: P=0, N=0 -> clamped to 1; strobe in RUN cycle 1; frame_done in cycle 2.
REQ-039 SHALL cover: n_rst low in RUN cycle 6 (P=4, N=3) -> all outputs 0 immediately; next start gives a full normal frame.
REQ-040 SHALL cover: start held high, P=2, N=1 -> frames repeat; frame_done every 4 cycles; mid-frame P change ignored.
